// File: rtl/booth_mult_seq_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the 3-bit window decoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        D_ZERO,
        D_P1,
        D_P2,
        D_N1,
        D_N2
    } digit_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}
    function automatic digit_e booth_decode(input logic [2:0] win);
        digit_e d;
        case (win)
            3'b001, 3'b010: d = D_P1;
            3'b011:         d = D_P2;
            3'b100:         d = D_N2;
            3'b101, 3'b110: d = D_N1;
            default:        d = D_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq. The producer/consumer
// side uses the master modport, the multiplier uses the slave modport.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [2*WIDTH-1:0]   in_acc;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_product
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_product
    );
endinterface

// File: rtl/booth_mult_seq_pp_gen.sv
// Radix-4 Booth partial-product generator: selects 0, +-a or +-2a from a
// 3-bit multiplier window. Result is WIDTH+2 bits, two's complement.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        a_i,
    input  logic                    signed_i,
    input  logic [2:0]              win_i,
    output logic signed [WIDTH+1:0] pp_o
);

    logic signed [WIDTH+1:0] a_ext;
    logic signed [WIDTH+1:0] a_dbl;

    // Two guard bits let -2a of the largest unsigned operand stay representable
    assign a_ext = signed_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
    assign a_dbl = a_ext <<< 1;

    always_comb begin
        pp_o = '0;
        case (booth_decode(win_i))
            D_P1:    pp_o = a_ext;
            D_P2:    pp_o = a_dbl;
            D_N1:    pp_o = ~a_ext + (WIDTH+2)'(1);
            D_N2:    pp_o = ~a_dbl + (WIDTH+2)'(1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock into a 2*WIDTH
// accumulator. Define BOOTH_MAC_EN to preload the accumulator with in_acc.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    booth_mult_seq_if.slave  bus
);

    localparam int N_S   = WIDTH / 2;
    localparam int N_U   = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(N_U + 1);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_width_check
        $fatal(1, "booth_mult_seq: WIDTH must be even and >= 4");
    end

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]        a_q, a_d;
    logic                    sgn_q, sgn_d;
    logic [WIDTH+2:0]        bwin_q, bwin_d;

    logic                    in_ready;
    logic                    accept;
    logic                    last_digit;
    logic                    b_ext;
    logic signed [WIDTH+1:0] pp;
    logic signed [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0]      acc_init;
    logic                    unused_acc;

    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .a_i      (a_q),
        .signed_i (sgn_q),
        .win_i    (bwin_q[2:0]),
        .pp_o     (pp)
    );

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = bus.in_valid && in_ready;
    assign last_digit = (cnt_q == (sgn_q ? CNT_W'(N_S - 1) : CNT_W'(N_U - 1)));
    assign b_ext      = bus.in_signed & bus.in_b[WIDTH-1];
    assign pp_ext     = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    assign unused_acc = ^bus.in_acc;

`ifdef BOOTH_MAC_EN
    assign acc_init = bus.in_acc;
`else
    assign acc_init = '0;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_product = acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        sgn_d   = sgn_q;
        bwin_d  = bwin_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    sgn_d   = bus.in_signed;
                    // b[-1]=0 at the bottom, two extension bits on top for the unsigned extra digit
                    bwin_d  = {b_ext, b_ext, bus.in_b, 1'b0};
                    acc_d   = acc_init;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_q + (pp_ext << {cnt_q, 1'b0});
                bwin_d = bwin_q >> 2;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Operand registers are only meaningful after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        sgn_q  <= sgn_d;
        bwin_q <= bwin_d;
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed WIDTH=8 vectors and
// corner sequences, plus randomised back-to-back WIDTH=16 traffic.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(8))  b8 ();
    booth_mult_seq_if #(.WIDTH(16)) b16 ();

    booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
    booth_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] acc;
        logic [15:0] prod;
        int          lat;
    } vec_t;

    vec_t tbl[7];
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mac_add(input logic [63:0] acc);
`ifdef BOOTH_MAC_EN
        return acc;
`else
        return 64'd0;
`endif
    endfunction

    // Plain integer multiply of the operands interpreted per the signed flag
    function automatic logic [63:0] ref_mul(input int w, input bit s,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] acc);
        longint sa, sb, p, mask;
        sa   = longint'(a) - ((s && a[w-1]) ? (longint'(1) << w) : longint'(0));
        sb   = longint'(b) - ((s && b[w-1]) ? (longint'(1) << w) : longint'(0));
        p    = sa * sb + longint'(mac_add(acc));
        mask = (longint'(1) << (2 * w)) - 1;
        return 64'(p & mask);
    endfunction

    task automatic send8(input bit s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] acc, output int lat, output logic [15:0] prod);
        int k;
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.in_signed = s;
        b8.in_a      = a;
        b8.in_b      = b;
        b8.in_acc    = acc;
        k = 0;
        while (!b8.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready %0b, expected 1", b8.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after accept; the result must not depend on them
        b8.in_valid  = 1'b0;
        b8.in_signed = ~s;
        b8.in_a      = 8'($urandom);
        b8.in_b      = 8'($urandom);
        b8.in_acc    = 16'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!b8.out_valid && lat < 40);
        prod = b8.out_product;
    endtask

    task automatic release8(input string name);
        @(negedge clk);
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_drop"}, {b8.out_valid, b8.in_ready}, {1'b0, 1'b1});
        b8.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] prod;
        bit seen;

        tbl[0] = '{1'b1, 8'h80, 8'h80, 16'd0,   16'h4000, 4};
        tbl[1] = '{1'b0, 8'hFF, 8'hFF, 16'd0,   16'hFE01, 5};
        tbl[2] = '{1'b1, 8'hFE, 8'h05, 16'd100, 16'hFFF6, 4};
        tbl[3] = '{1'b0, 8'h80, 8'h80, 16'd0,   16'h4000, 5};
        tbl[4] = '{1'b1, 8'h7F, 8'h80, 16'd0,   16'hC080, 4};
        tbl[5] = '{1'b0, 8'h00, 8'h55, 16'd0,   16'h0000, 5};
        tbl[6] = '{1'b1, 8'hFF, 8'hFF, 16'd0,   16'h0001, 4};

        rst = 1'b1;
        b8.in_valid = 1'b0;  b8.in_signed = 1'b0; b8.in_a = '0; b8.in_b = '0;
        b8.in_acc = '0;      b8.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_signed = 1'b0; b16.in_a = '0; b16.in_b = '0;
        b16.in_acc = '0;     b16.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset8", {b8.in_ready, b8.out_valid, b8.out_product}, 18'd0);
        check("reset16", {b16.in_ready, b16.out_valid, b16.out_product}, 34'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", b8.in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            send8(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].acc, lat, prod);
            check($sformatf("vec%0d_prod", i), prod, 64'(tbl[i].prod) + mac_add(64'(tbl[i].acc)) & 64'hFFFF);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            release8($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready stays low
        send8(1'b1, 8'd7, 8'hFD, 16'd0, lat, prod);
        check("hold_prod", prod, 16'hFFEB);
        check("hold_lat", lat, 4);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_c%0d", i), {b8.out_valid, b8.in_ready, b8.out_product},
                  {1'b1, 1'b0, 16'hFFEB});
        end
        release8("hold");

        // Reset during RUN abandons the transaction
        @(negedge clk);
        b8.in_valid = 1'b1; b8.in_signed = 1'b1; b8.in_a = 8'd3; b8.in_b = 8'd5;
        b8.in_acc = 16'd0;
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", b8.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_after_ready", b8.in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (b8.out_valid) seen = 1'b1;
        end
        check("rst_no_valid", seen, 1'b0);
        send8(1'b1, 8'd3, 8'd5, 16'd0, lat, prod);
        check("post_rst_prod", prod, 16'd15);
        check("post_rst_lat", lat, 4);
        release8("post_rst");

        // Randomised WIDTH=16 traffic with back-to-back offers and random backpressure
        @(negedge clk);
        fork
            begin : producer
                for (int t = 0; t < 40; t++) begin
                    int gap, k;
                    bit s;
                    logic [15:0] a, b;
                    logic [31:0] acc;
                    gap = ($urandom % 3 == 0) ? int'($urandom % 3) : 0;
                    if (gap > 0) begin
                        b16.in_valid = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                    s   = 1'($urandom);
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    acc = $urandom;
                    b16.in_valid  = 1'b1;
                    b16.in_signed = s;
                    b16.in_a      = a;
                    b16.in_b      = b;
                    b16.in_acc    = acc;
                    k = 0;
                    while (!b16.in_ready && k < 100) begin
                        @(negedge clk);
                        k++;
                    end
                    if (k >= 100) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rand16_accept: in_ready %0b, expected 1", b16.in_ready);
                    end
                    exp_q.push_back(ref_mul(16, s, 64'(a), 64'(b), 64'(acc)));
                    @(negedge clk);
                end
                b16.in_valid = 1'b0;
            end
            begin : consumer
                int got, cyc;
                logic [63:0] e;
                got = 0;
                cyc = 0;
                while (got < 40 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    b16.out_ready = ($urandom % 4) != 0;
                    if (b16.out_valid && b16.out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rand16_extra: got %0h, expected no result", b16.out_product);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("rand16_%0d", got), b16.out_product, e);
                        end
                        got++;
                    end
                end
                check("rand16_count", got, 40);
                @(negedge clk);
                b16.out_ready = 1'b1;
            end
        join

        check("rand16_queue_empty", exp_q.size(), 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b16.out_valid) seen = 1'b1;
        end
        check("rand16_no_dup", seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the team's fixed 8-bit combinational Booth multiplier.
- Retires one Booth digit per clock into a 2*WIDTH accumulator.
- Supports signed and unsigned operands per transaction.
- Valid/ready handshakes on both sides. It sits in the FMAC datapath ahead of the adder/normaliser.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration-time check, fatal otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set available
- in_ready  output  1  block can accept operands
- in_signed  input  1  1: operands two's complement; 0: unsigned
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier (Booth-recoded)
- in_acc  input  2*WIDTH  addend; used only with BOOTH_MAC_EN, otherwise ignored
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_product  output  2*WIDTH  product (plus addend if enabled), mod 2^(2*WIDTH)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, out_valid=0, out_product=0, digit counter=0.
- in_ready is 0 during any cycle rst=1.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_a/in_b/in_signed (and in_acc), clear the accumulator (or load in_acc), counter=0, go to RUN.
  - RUN: in_ready=0. Each cycle, digit i = f(b[2i+1], b[2i], b[2i-1]), with b[-1]=0. Add pp_i<<(2i) to the accumulator and increment the counter. After the last digit, go to DONE.
  - DONE: out_valid=1. out_product is the accumulator, held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops the next cycle.
- Digit count N:
  - Signed: N = WIDTH/2.
  - Unsigned: N = WIDTH/2+1. in_b is zero-extended by 2 bits and in_a is zero-extended, so the top digit handles the MSB.
- Digit mapping: 000/111->0, 001/010->+a, 011->+2a, 100->-2a, 101/110->-a.
- pp_i is WIDTH+2 bits (a sign- or zero-extended, shifted for 2a). Negation is invert+1. pp_i is sign-extended to 2*WIDTH before the add.
- Accumulator arithmetic is mod 2^(2*WIDTH); carry-out is discarded.
- Latency: with acceptance on edge E0, out_valid is high after edge EN (N cycles). Throughput is one result per N+2 cycles minimum.
- Operand inputs are sampled only at the accept handshake; changes afterwards have no effect.
- out_ready while out_valid=0 is ignored. in_valid in RUN/DONE is not accepted, and the transaction is not lost: the producer must hold it.
- rst during RUN or DONE: the transaction is abandoned, no out_valid is produced, and the block is in IDLE the following cycle.

Optional Feature:
- Macro: BOOTH_MAC_EN
- Defined: at accept, the accumulator is loaded with in_acc instead of 0. out_product = a*b + in_acc, mod 2^(2*WIDTH). Latency is unchanged.
- Undefined: in_acc is ignored (port kept, unused). out_product = a*b.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE}
  - digit enum {D_ZERO, D_P1, D_P2, D_N1, D_N2}
  - function decoding a 3-bit window to a digit
- Sub-module booth_pp_gen (combinational): a, signed flag and 3-bit window in, WIDTH+2 partial product out. Parametrised by WIDTH.
- The top level holds the FSM, counter, operand registers and accumulator.

Test Plan:
- WIDTH=8, signed, a=-128, b=-128 -> out_product=16'h4000 (16384), out_valid high exactly 4 cycles after accept.
- WIDTH=8, unsigned, a=255, b=255 -> out_product=16'hFE01 (65025), out_valid 5 cycles after accept.
- WIDTH=8, signed, a=7, b=-3 -> 16'hFFEB (-21). Hold out_ready=0 for 6 cycles: out_valid and out_product stay stable and in_ready stays 0. Release -> IDLE next cycle.
- Assert rst on RUN cycle 2 -> out_valid never asserts, in_ready=1 the cycle after rst deasserts. Then 3*5 -> 15.
- WIDTH=16, randomised signed/unsigned, back-to-back in_valid -> each result matches the reference model; no transaction lost or duplicated.
- BOOTH_MAC_EN defined, WIDTH=8, signed, a=-2, b=5, in_acc=100 -> out_product=90. BOOTH_MAC_EN undefined, same stimulus -> -10 (16'hFFF6).
